multicycle_controller: RTL and testbench

Control unit for the multicycle RISC-V datapath: a Moore state machine that sequences fetch, decode, execute, memory and writeback, plus an ALU decoder that drives the 3-bit `alucontrol` code consumed by the ALU. It sits between the instruction register and the datapath. It issues every mux select, write enable and ALU operation for RV32I `lw`, `sw`, R-type, I-type ALU, `beq` and `jal`.

---
 rtl/riscape_pkg.sv | 41 ++++
 rtl/alu_decoder.sv | 37 +++
 rtl/multicycle_controller.sv | 161 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscape_pkg.sv
// Shared definitions for the multicycle RISC-V control path.
// Holds the ALU operation encodings, the RV32I opcodes the controller
// recognises, the internal aluop codes and the controller state enum.
package riscape_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_op_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // aluop: how the ALU decoder should interpret funct3/funct7
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ
    } ctrl_state_e;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder.
// Ports:
//   aluop      in  2 : 00 add, 01 sub, 10 decode funct3, 11 add
//   funct3     in  3 : instr[14:12]
//   funct7b5   in  1 : instr[30]
//   op5        in  1 : instr[5], distinguishes R-type from I-type
//   alucontrol out 3 : ALU operation code
module alu_decoder
    import riscape_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output alu_op_e    alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // addi never subtracts, even when instr[30] happens to be set
                    3'b000:  alucontrol = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b100:  alucontrol = ALU_XOR;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control unit for the multicycle RV32I datapath (lw, sw, R-type,
// I-type ALU, beq, jal).
// Ports:
//   clk, reset (sync, active-high)
//   op, funct3, funct7b5 : instruction fields;  zero : ALU zero flag
//   pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
//   regwrite, immsrc, alucontrol : datapath controls
//   illegal : high for the DECODE cycle of an unrecognised opcode
//
// state      | meaning
// FETCH      | read instruction, PC <= PC + 4
// DECODE     | read registers, ALU forms branch target
// MEMADR     | rs1 + imm for load/store
// MEMREAD    | read data memory at ALUOut
// MEMWB      | write loaded data to rd
// MEMWRITE   | write rs2 to data memory
// EXECUTER   | R-type ALU op
// EXECUTEI   | I-type ALU op
// ALUWB      | write ALUOut to rd
// JAL        | PC <= target, ALU forms OldPC + 4
// BEQ        | compare rs1/rs2, PC <= target on zero
module multicycle_controller
    import riscape_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic       regwrite,
    output logic [1:0] immsrc,
    output logic [2:0] alucontrol,
    output logic       illegal
);

    ctrl_state_e state_q, state_d;
    logic [1:0]  aluop;
    logic        pcupdate, branch, memwrite_s, irwrite_s, regwrite_s, illegal_s;
    alu_op_e     alu_sel;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = S_FETCH;
        pcupdate   = 1'b0;
        branch     = 1'b0;
        adrsrc     = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        illegal_s  = 1'b0;
        resultsrc  = 2'b00;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        aluop      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                irwrite_s = 1'b1;
                pcupdate  = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BRANCH:         state_d = S_BEQ;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regwrite_s = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc     = 1'b1;
                memwrite_s = 1'b1;
            end
            S_EXECUTER: begin
                alusrca = 2'b10;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: regwrite_s = 1'b1;
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_BEQ: begin
                alusrca = 2'b10;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset kills every architectural write in the same cycle so an
    // interrupted instruction never partially retires.
    assign pcwrite  = ~reset & (pcupdate | (branch & zero));
    assign memwrite = ~reset & memwrite_s;
    assign irwrite  = ~reset & irwrite_s;
    assign regwrite = ~reset & regwrite_s;
    assign illegal  = ~reset & illegal_s;

    always_comb begin
        case (op)
            OP_STORE:  immsrc = 2'b01;
            OP_BRANCH: immsrc = 2'b10;
            OP_JAL:    immsrc = 2'b11;
            default:   immsrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alucontrol (alu_sel)
    );

    assign alucontrol = alu_sel;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a table of per-cycle input/expected
// output records walked through consecutive instructions, followed by
// hand-built reset-interruption sequences.
module tb_multicycle_controller;

    localparam logic [6:0] L = 7'b0000011;
    localparam logic [6:0] S = 7'b0100011;
    localparam logic [6:0] R = 7'b0110011;
    localparam logic [6:0] I = 7'b0010011;
    localparam logic [6:0] J = 7'b1101111;
    localparam logic [6:0] B = 7'b1100011;
    localparam logic [6:0] X = 7'b0000000;

    typedef struct packed {
        logic       pcwrite;
        logic       adrsrc;
        logic       memwrite;
        logic       irwrite;
        logic [1:0] resultsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       regwrite;
        logic [1:0] immsrc;
        logic [2:0] alucontrol;
        logic       illegal;
    } out_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        out_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic funct7b5 = 1'b0;
    logic zero = 1'b0;
    logic pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;
    out_t act;

    int n_checks = 0;
    int n_fail = 0;
    vec_t tbl[$];
    out_t sb_q[$];
    string nm_q[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .resultsrc  (resultsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .regwrite   (regwrite),
        .immsrc     (immsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal)
    );

    assign act = {pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca,
                  alusrcb, regwrite, immsrc, alucontrol, illegal};

    // Expected outputs of one state, straight from the state/output list.
    function automatic out_t e(input string st, input logic [1:0] imm,
                               input logic [2:0] alu, input logic pcw);
        out_t o;
        o = '0;
        o.immsrc = imm;
        case (st)
            "FETCH":    begin o.irwrite = 1; o.pcwrite = 1; o.alusrcb = 2'b10; o.resultsrc = 2'b10; end
            "DECODE":   begin o.alusrca = 2'b01; o.alusrcb = 2'b01; end
            "ILLEGAL":  begin o.alusrca = 2'b01; o.alusrcb = 2'b01; o.illegal = 1; end
            "MEMADR":   begin o.alusrca = 2'b10; o.alusrcb = 2'b01; end
            "MEMREAD":  o.adrsrc = 1;
            "MEMWB":    begin o.resultsrc = 2'b01; o.regwrite = 1; end
            "MEMWRITE": begin o.adrsrc = 1; o.memwrite = 1; end
            "EXECR":    begin o.alusrca = 2'b10; o.alucontrol = alu; end
            "EXECI":    begin o.alusrca = 2'b10; o.alusrcb = 2'b01; o.alucontrol = alu; end
            "ALUWB":    o.regwrite = 1;
            "JAL":      begin o.alusrca = 2'b01; o.alusrcb = 2'b10; o.pcwrite = 1; end
            "BEQ":      begin o.alusrca = 2'b10; o.alucontrol = 3'b001; o.pcwrite = pcw; end
            default:    o = '1;
        endcase
        return o;
    endfunction

    function automatic out_t gate(input out_t o);
        out_t g;
        g = o;
        g.pcwrite = 0; g.memwrite = 0; g.irwrite = 0; g.regwrite = 0; g.illegal = 0;
        return g;
    endfunction

    task automatic add(input string nm, input logic r, input logic [6:0] o,
                       input logic [2:0] f3, input logic f7, input logic z, input out_t x);
        vec_t v;
        v.name = nm; v.rst = r; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = x;
        tbl.push_back(v);
    endtask

    task automatic check();
        out_t x;
        string nm;
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty: no expected entry queued");
            return;
        end
        x = sb_q.pop_front();
        nm = nm_q.pop_front();
        n_checks++;
        if (act !== x) begin
            n_fail++;
            $display("FAIL %s: got pcw=%b adr=%b mw=%b ir=%b rs=%b a=%b b=%b rw=%b imm=%b alu=%b ill=%b, expected pcw=%b adr=%b mw=%b ir=%b rs=%b a=%b b=%b rw=%b imm=%b alu=%b ill=%b",
                     nm, act.pcwrite, act.adrsrc, act.memwrite, act.irwrite, act.resultsrc,
                     act.alusrca, act.alusrcb, act.regwrite, act.immsrc, act.alucontrol, act.illegal,
                     x.pcwrite, x.adrsrc, x.memwrite, x.irwrite, x.resultsrc,
                     x.alusrca, x.alusrcb, x.regwrite, x.immsrc, x.alucontrol, x.illegal);
        end
    endtask

    // One cycle: drive just after the rising edge, compare at the falling edge.
    task automatic step(input vec_t v);
        @(posedge clk);
        #1;
        reset = v.rst; op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
        sb_q.push_back(v.exp);
        nm_q.push_back(v.name);
        @(negedge clk);
        check();
    endtask

    initial begin
        // reset cycle: FETCH selects visible, writes masked
        add("reset_fetch",   1, R, 3'b000, 1, 0, gate(e("FETCH", 2'b00, 0, 0)));
        // R-type sub; zero held high to show it is ignored outside BEQ
        add("rsub_fetch",    0, R, 3'b000, 1, 1, e("FETCH",  2'b00, 0, 0));
        add("rsub_decode",   0, R, 3'b000, 1, 1, e("DECODE", 2'b00, 0, 0));
        add("rsub_exec",     0, R, 3'b000, 1, 1, e("EXECR",  2'b00, 3'b001, 0));
        add("rsub_aluwb",    0, R, 3'b000, 1, 1, e("ALUWB",  2'b00, 0, 0));
        add("rslt_fetch",    0, R, 3'b010, 0, 0, e("FETCH",  2'b00, 0, 0));
        add("rslt_decode",   0, R, 3'b010, 0, 0, e("DECODE", 2'b00, 0, 0));
        add("rslt_exec",     0, R, 3'b010, 0, 0, e("EXECR",  2'b00, 3'b101, 0));
        add("rslt_aluwb",    0, R, 3'b010, 0, 0, e("ALUWB",  2'b00, 0, 0));
        add("ror_fetch",     0, R, 3'b110, 0, 0, e("FETCH",  2'b00, 0, 0));
        add("ror_decode",    0, R, 3'b110, 0, 0, e("DECODE", 2'b00, 0, 0));
        add("ror_exec",      0, R, 3'b110, 0, 0, e("EXECR",  2'b00, 3'b011, 0));
        add("ror_aluwb",     0, R, 3'b110, 0, 0, e("ALUWB",  2'b00, 0, 0));
        add("rand_fetch",    0, R, 3'b111, 0, 0, e("FETCH",  2'b00, 0, 0));
        add("rand_decode",   0, R, 3'b111, 0, 0, e("DECODE", 2'b00, 0, 0));
        add("rand_exec",     0, R, 3'b111, 0, 0, e("EXECR",  2'b00, 3'b010, 0));
        add("rand_aluwb",    0, R, 3'b111, 0, 0, e("ALUWB",  2'b00, 0, 0));
        add("addi_fetch",    0, I, 3'b000, 1, 0, e("FETCH",  2'b00, 0, 0));
        add("addi_decode",   0, I, 3'b000, 1, 0, e("DECODE", 2'b00, 0, 0));
        add("addi_f7_exec",  0, I, 3'b000, 1, 0, e("EXECI",  2'b00, 3'b000, 0));
        add("addi_aluwb",    0, I, 3'b000, 1, 0, e("ALUWB",  2'b00, 0, 0));
        add("xori_fetch",    0, I, 3'b100, 0, 0, e("FETCH",  2'b00, 0, 0));
        add("xori_decode",   0, I, 3'b100, 0, 0, e("DECODE", 2'b00, 0, 0));
        add("xori_exec",     0, I, 3'b100, 0, 0, e("EXECI",  2'b00, 3'b100, 0));
        add("xori_aluwb",    0, I, 3'b100, 0, 0, e("ALUWB",  2'b00, 0, 0));
        add("slli_fetch",    0, I, 3'b001, 0, 0, e("FETCH",  2'b00, 0, 0));
        add("slli_decode",   0, I, 3'b001, 0, 0, e("DECODE", 2'b00, 0, 0));
        add("slli_exec",     0, I, 3'b001, 0, 0, e("EXECI",  2'b00, 3'b000, 0));
        add("slli_aluwb",    0, I, 3'b001, 0, 0, e("ALUWB",  2'b00, 0, 0));
        add("lw_fetch",      0, L, 3'b010, 0, 1, e("FETCH",   2'b00, 0, 0));
        add("lw_decode",     0, L, 3'b010, 0, 1, e("DECODE",  2'b00, 0, 0));
        add("lw_memadr",     0, L, 3'b010, 0, 1, e("MEMADR",  2'b00, 0, 0));
        add("lw_memread",    0, L, 3'b010, 0, 1, e("MEMREAD", 2'b00, 0, 0));
        add("lw_memwb",      0, L, 3'b010, 0, 1, e("MEMWB",   2'b00, 0, 0));
        add("sw_fetch",      0, S, 3'b010, 0, 0, e("FETCH",    2'b01, 0, 0));
        add("sw_decode",     0, S, 3'b010, 0, 0, e("DECODE",   2'b01, 0, 0));
        add("sw_memadr",     0, S, 3'b010, 0, 0, e("MEMADR",   2'b01, 0, 0));
        add("sw_memwrite",   0, S, 3'b010, 0, 0, e("MEMWRITE", 2'b01, 0, 0));
        add("beq1_fetch",    0, B, 3'b000, 0, 1, e("FETCH",  2'b10, 0, 0));
        add("beq1_decode",   0, B, 3'b000, 0, 1, e("DECODE", 2'b10, 0, 0));
        add("beq1_taken",    0, B, 3'b000, 0, 1, e("BEQ",    2'b10, 0, 1));
        add("beq0_fetch",    0, B, 3'b000, 0, 0, e("FETCH",  2'b10, 0, 0));
        add("beq0_decode",   0, B, 3'b000, 0, 0, e("DECODE", 2'b10, 0, 0));
        add("beq0_nottaken", 0, B, 3'b000, 0, 0, e("BEQ",    2'b10, 0, 0));
        add("jal_fetch",     0, J, 3'b000, 0, 0, e("FETCH",  2'b11, 0, 0));
        add("jal_decode",    0, J, 3'b000, 0, 0, e("DECODE", 2'b11, 0, 0));
        add("jal_jal",       0, J, 3'b000, 0, 0, e("JAL",    2'b11, 0, 0));
        add("jal_aluwb",     0, J, 3'b000, 0, 0, e("ALUWB",  2'b11, 0, 0));
        add("ill_fetch",     0, X, 3'b000, 0, 0, e("FETCH",   2'b00, 0, 0));
        add("ill_decode",    0, X, 3'b000, 0, 0, e("ILLEGAL", 2'b00, 0, 0));
        add("ill_refetch",   0, R, 3'b000, 0, 0, e("FETCH",   2'b00, 0, 0));
        add("ill_next_dec",  0, R, 3'b000, 0, 0, e("DECODE",  2'b00, 0, 0));
        add("ill_next_exec", 0, R, 3'b000, 0, 0, e("EXECR",   2'b00, 3'b000, 0));
        add("ill_next_wb",   0, R, 3'b000, 0, 0, e("ALUWB",   2'b00, 0, 0));

        reset = 1'b1;
        repeat (2) @(posedge clk);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset landing in MEMWRITE: store suppressed, FETCH after the edge.
        tbl.delete();
        add("rsw_fetch",     0, S, 3'b010, 0, 0, e("FETCH",  2'b01, 0, 0));
        add("rsw_decode",    0, S, 3'b010, 0, 0, e("DECODE", 2'b01, 0, 0));
        add("rsw_memadr",    0, S, 3'b010, 0, 0, e("MEMADR", 2'b01, 0, 0));
        add("rsw_memwrite",  1, S, 3'b010, 0, 0, gate(e("MEMWRITE", 2'b01, 0, 0)));
        add("rsw_after",     0, S, 3'b010, 0, 0, e("FETCH",  2'b01, 0, 0));
        // Reset landing in ALUWB: register write suppressed.
        add("rwb_decode",    0, R, 3'b000, 1, 0, e("DECODE", 2'b00, 0, 0));
        add("rwb_exec",      0, R, 3'b000, 1, 0, e("EXECR",  2'b00, 3'b001, 0));
        add("rwb_aluwb",     1, R, 3'b000, 1, 0, gate(e("ALUWB", 2'b00, 0, 0)));
        add("rwb_after",     0, R, 3'b000, 1, 0, e("FETCH",  2'b00, 0, 0));
        // Reset during DECODE of an illegal opcode: no illegal pulse.
        add("rill_decode",   1, X, 3'b000, 0, 0, gate(e("ILLEGAL", 2'b00, 0, 0)));
        add("rill_after",    0, J, 3'b000, 0, 0, e("FETCH",  2'b11, 0, 0));
        // Reset during JAL: PC update suppressed.
        add("rjal_decode",   0, J, 3'b000, 0, 0, e("DECODE", 2'b11, 0, 0));
        add("rjal_jal",      1, J, 3'b000, 0, 0, gate(e("JAL", 2'b11, 0, 0)));
        add("rjal_after",    0, B, 3'b000, 0, 1, e("FETCH",  2'b10, 0, 0));
        // Reset during a taken BEQ: branch write suppressed.
        add("rbeq_decode",   0, B, 3'b000, 0, 1, e("DECODE", 2'b10, 0, 0));
        add("rbeq_beq",      1, B, 3'b000, 0, 1, gate(e("BEQ", 2'b10, 0, 1)));
        add("rbeq_after",    0, L, 3'b000, 0, 0, e("FETCH",  2'b00, 0, 0));
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        if (sb_q.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
